// File: rtl/drs_trigger_ctrl.sv
// drs_trigger_ctrl: trigger sequencer between the registered LVDS trigger
// input and the DRS control block.
//   - rising-edge detect on trigger_i, gated by enable_i
//   - programmable coarse delay, one-cycle start pulse to the DRS controller
//   - deadtime: waits for the DRS busy pulse (with timeout) plus a holdoff
//   - accepted-event (wrapping) and lost-event (saturating) counters
// Optional feature: define TRIG_PRESCALE_EN to add prescale_i[7:0]; only
// every (prescale_i+1)-th edge accepted in IDLE then proceeds to fire.
// BUSY_TIMEOUT must be at least 2.

module drs_trigger_ctrl #(
    parameter int DELAY_W      = 8,
    parameter int HOLDOFF_W    = 12,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 trigger_i,
    input  logic                 enable_i,
    input  logic                 resync_i,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic [HOLDOFF_W-1:0] holdoff_i,
`ifdef TRIG_PRESCALE_EN
    input  logic [7:0]           prescale_i,
`endif
    input  logic                 drs_busy_i,
    output logic                 drs_trigger_o,
    output logic                 busy_o,
    output logic [31:0]          event_counter_o,
    output logic [15:0]          lost_event_counter_o,
    output logic                 timeout_o
);

    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    // Loaded in FIRE; reaching 1 in WAIT_BUSY means BUSY_TIMEOUT cycles
    // have elapsed since FIRE once the flag registers.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DELAY     = 3'd1,
        ST_FIRE      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    state_t               state_r;
    logic                 trig_q_r;
    logic [DELAY_W-1:0]   delay_cnt_r;
    logic [TMO_W-1:0]     tmo_cnt_r;
    logic                 busy_seen_r;
    logic [HOLDOFF_W-1:0] hold_cnt_r;
    logic                 drs_trigger_r;
    logic                 busy_r;
    logic [31:0]          event_cnt_r;
    logic [15:0]          lost_cnt_r;
    logic                 timeout_r;

    logic                 edge_s;
    logic                 req_s;
    logic                 idle_req_s;
    logic                 accept_s;
    logic                 lost_inc_s;
    logic                 event_inc_s;
    logic                 busy_fall_s;
    logic                 timeout_hit_s;
    logic                 wait_done_s;

    // Saturating increment for the lost-event counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
        if (inc && (value != 16'hFFFF)) begin
            return value + 16'd1;
        end else begin
            return value;
        end
    endfunction

    assign edge_s     = trigger_i & ~trig_q_r;
    assign req_s      = edge_s & enable_i;
    assign idle_req_s = req_s & (state_r == ST_IDLE);

`ifdef TRIG_PRESCALE_EN
    logic [7:0] presc_cnt_r;
    logic       presc_hit_s;

    assign presc_hit_s = (presc_cnt_r == prescale_i);
    assign accept_s    = idle_req_s & presc_hit_s;

    // Prescale counter: counts edges seen in IDLE, wraps on the accepted one
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_cnt_r <= 8'd0;
        end else if (resync_i) begin
            presc_cnt_r <= 8'd0;
        end else if (idle_req_s) begin
            if (presc_hit_s) begin
                presc_cnt_r <= 8'd0;
            end else begin
                presc_cnt_r <= presc_cnt_r + 8'd1;
            end
        end
    end
`else
    assign accept_s = idle_req_s;
`endif

    // Decode deadtime events: lost edges, counted fires, end of busy wait
    always_comb begin
        lost_inc_s    = 1'b0;
        event_inc_s   = 1'b0;
        busy_fall_s   = 1'b0;
        timeout_hit_s = 1'b0;
        if (state_r != ST_IDLE) begin
            lost_inc_s = req_s;
        end else begin
            lost_inc_s = 1'b0;
        end
        if (state_r == ST_FIRE) begin
            event_inc_s = 1'b1;
        end else begin
            event_inc_s = 1'b0;
        end
        if (state_r == ST_WAIT_BUSY) begin
            busy_fall_s   = busy_seen_r & ~drs_busy_i;
            timeout_hit_s = ~busy_seen_r & ~drs_busy_i & (tmo_cnt_r == TMO_W'(1));
        end else begin
            busy_fall_s   = 1'b0;
            timeout_hit_s = 1'b0;
        end
        wait_done_s = busy_fall_s | timeout_hit_s;
    end

    // Trigger level delayed one cycle for rising-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            trig_q_r <= 1'b0;
        end else begin
            trig_q_r <= trigger_i;
        end
    end

    // Sequencer FSM with registered start pulse and busy flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            delay_cnt_r   <= {DELAY_W{1'b0}};
            tmo_cnt_r     <= {TMO_W{1'b0}};
            busy_seen_r   <= 1'b0;
            hold_cnt_r    <= {HOLDOFF_W{1'b0}};
            drs_trigger_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            drs_trigger_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        busy_r <= 1'b1;
                        if (delay_i == {DELAY_W{1'b0}}) begin
                            state_r       <= ST_FIRE;
                            drs_trigger_r <= 1'b1;
                        end else begin
                            state_r     <= ST_DELAY;
                            delay_cnt_r <= delay_i;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_r == DELAY_W'(1)) begin
                        state_r       <= ST_FIRE;
                        drs_trigger_r <= 1'b1;
                        delay_cnt_r   <= {DELAY_W{1'b0}};
                    end else begin
                        delay_cnt_r <= delay_cnt_r - DELAY_W'(1);
                    end
                end
                ST_FIRE: begin
                    state_r     <= ST_WAIT_BUSY;
                    tmo_cnt_r   <= TMO_LOAD;
                    // busy already high during the start pulse counts as risen
                    busy_seen_r <= drs_busy_i;
                end
                ST_WAIT_BUSY: begin
                    if (wait_done_s) begin
                        busy_seen_r <= 1'b0;
                        // holdoff of zero skips the HOLDOFF state entirely
                        if (holdoff_i == {HOLDOFF_W{1'b0}}) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r    <= ST_HOLDOFF;
                            hold_cnt_r <= holdoff_i;
                        end
                    end else if (!busy_seen_r) begin
                        if (drs_busy_i) begin
                            busy_seen_r <= 1'b1;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r - TMO_W'(1);
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_r == HOLDOFF_W'(1)) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        hold_cnt_r <= {HOLDOFF_W{1'b0}};
                    end else begin
                        hold_cnt_r <= hold_cnt_r - HOLDOFF_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Event/lost counters and sticky timeout flag; resync overrides updates
    always_ff @(posedge clock) begin
        if (reset) begin
            event_cnt_r <= 32'd0;
            lost_cnt_r  <= 16'd0;
            timeout_r   <= 1'b0;
        end else if (resync_i) begin
            event_cnt_r <= 32'd0;
            lost_cnt_r  <= 16'd0;
            timeout_r   <= 1'b0;
        end else begin
            if (event_inc_s) begin
                event_cnt_r <= event_cnt_r + 32'd1;
            end
            lost_cnt_r <= sat_inc16(lost_cnt_r, lost_inc_s);
            if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign drs_trigger_o        = drs_trigger_r;
    assign busy_o               = busy_r;
    assign event_counter_o      = event_cnt_r;
    assign lost_event_counter_o = lost_cnt_r;
    assign timeout_o            = timeout_r;

endmodule

// File: tb/tb_drs_trigger_ctrl.sv
// Self-checking bench for drs_trigger_ctrl: a per-cycle vector table for the
// basic fire behaviour plus directed sequences for delay/holdoff, deadtime
// loss and saturation, busy timeout, resync collision and reset mid-delay.

module tb_drs_trigger_ctrl;

    logic        clock;
    logic        reset;
    logic        trigger;
    logic        enable;
    logic        resync;
    logic [7:0]  delay;
    logic [11:0] holdoff;
    logic        drs_busy;
    logic        drs_trigger;
    logic        busy;
    logic [31:0] event_counter;
    logic [15:0] lost_counter;
    logic        timeout;
`ifdef TRIG_PRESCALE_EN
    logic [7:0]  prescale;
`endif

    int total = 0;
    int bad   = 0;

    drs_trigger_ctrl #(
        .DELAY_W      (8),
        .HOLDOFF_W    (12),
        .BUSY_TIMEOUT (64)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .trigger_i            (trigger),
        .enable_i             (enable),
        .resync_i             (resync),
        .delay_i              (delay),
        .holdoff_i            (holdoff),
`ifdef TRIG_PRESCALE_EN
        .prescale_i           (prescale),
`endif
        .drs_busy_i           (drs_busy),
        .drs_trigger_o        (drs_trigger),
        .busy_o               (busy),
        .event_counter_o      (event_counter),
        .lost_event_counter_o (lost_counter),
        .timeout_o            (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        trig;
        logic        en;
        logic        dbusy;
        logic        exp_drs;
        logic        exp_busy;
        logic [31:0] exp_evt;
        logic [15:0] exp_lost;
    } vec_t;

    localparam int NVEC = 56;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // Basic-fire table: cycle c drives inputs and expects outputs of cycle c.
        for (int c = 0; c < NVEC; c++) begin
            vecs[c].trig     = (c >= 10 && c <= 14) || (c >= 24 && c <= 26) ||
                               (c >= 30 && c <= 45) || (c >= 48 && c <= 49);
            vecs[c].en       = !(c >= 24 && c <= 26);
            vecs[c].dbusy    = (c >= 13 && c <= 20) || (c >= 33 && c <= 35) ||
                               (c >= 51 && c <= 52);
            vecs[c].exp_drs  = (c == 11) || (c == 31) || (c == 49);
            vecs[c].exp_busy = (c >= 11 && c <= 21) || (c >= 31 && c <= 36) ||
                               (c >= 49 && c <= 53);
            vecs[c].exp_evt  = (c <= 11) ? 32'd0 : (c <= 31) ? 32'd1 :
                               (c <= 49) ? 32'd2 : 32'd3;
            vecs[c].exp_lost = 16'd0;
        end

        reset    = 1'b1;
        trigger  = 1'b0;
        enable   = 1'b1;
        resync   = 1'b0;
        delay    = 8'd0;
        holdoff  = 12'd0;
        drs_busy = 1'b0;
`ifdef TRIG_PRESCALE_EN
        prescale = 8'd0;
`endif
        repeat (3) @(negedge clock);
        check("reset drs_trigger", 32'(drs_trigger), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset event_counter", event_counter, 32'd0);
        check("reset lost_counter", 32'(lost_counter), 32'd0);
        check("reset timeout", 32'(timeout), 32'd0);
        reset = 1'b0;

        // Table: single fire, held-high trigger, disabled edge
        for (int c = 0; c < NVEC; c++) begin
            @(negedge clock);
            check($sformatf("tbl drs c=%0d", c), 32'(drs_trigger), 32'(vecs[c].exp_drs));
            check($sformatf("tbl busy c=%0d", c), 32'(busy), 32'(vecs[c].exp_busy));
            check($sformatf("tbl evt c=%0d", c), event_counter, vecs[c].exp_evt);
            check($sformatf("tbl lost c=%0d", c), 32'(lost_counter), 32'(vecs[c].exp_lost));
            trigger  = vecs[c].trig;
            enable   = vecs[c].en;
            drs_busy = vecs[c].dbusy;
        end

        // Delay 5, holdoff 10: pulse at edge+6, busy 10 cycles past busy fall
        holdoff = 12'd10;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clock);
            check($sformatf("dly drs k=%0d", k), 32'(drs_trigger), 32'(k == 6));
            check($sformatf("dly busy k=%0d", k), 32'(busy), 32'(k >= 1 && k <= 22));
            trigger  = (k == 0);
            delay    = (k == 0) ? 8'd5 : 8'd0;
            drs_busy = (k >= 8 && k <= 11);
        end
        check("dly evt", event_counter, 32'd4);

        // Deadtime loss: 3 enabled edges in WAIT_BUSY, one disabled edge
        holdoff = 12'd0;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clock);
            check($sformatf("loss drs k=%0d", k), 32'(drs_trigger), 32'(k == 1));
            check($sformatf("loss busy k=%0d", k), 32'(busy), 32'(k >= 1 && k <= 21));
            trigger  = (k == 0) || (k == 4) || (k == 6) || (k == 8) || (k == 10);
            enable   = (k != 10);
            drs_busy = (k >= 3 && k <= 20);
        end
        check("loss lost", 32'(lost_counter), 32'd3);
        check("loss evt", event_counter, 32'd5);

        // Saturation: preset lost count to 0xFFFF, one more lost edge
        for (int k = 0; k <= 14; k++) begin
            @(negedge clock);
            if (k == 4) release dut.lost_cnt_r;
            check($sformatf("sat drs k=%0d", k), 32'(drs_trigger), 32'(k == 1));
            check($sformatf("sat busy k=%0d", k), 32'(busy), 32'(k >= 1 && k <= 10));
            if (k == 5) check("sat preset", 32'(lost_counter), 32'h0000FFFF);
            if (k == 8) check("sat hold", 32'(lost_counter), 32'h0000FFFF);
            trigger  = (k == 0) || (k == 6);
            drs_busy = (k >= 3 && k <= 9);
            if (k == 3) force dut.lost_cnt_r = 16'hFFFF;
        end
        check("sat evt", event_counter, 32'd6);

        // Timeout: no DRS busy, flag 64 cycles after FIRE, holdoff 3, then refire
        holdoff = 12'd3;
        for (int k = 0; k <= 80; k++) begin
            @(negedge clock);
            check($sformatf("tmo flag k=%0d", k), 32'(timeout), 32'(k >= 65));
            check($sformatf("tmo drs k=%0d", k), 32'(drs_trigger), 32'(k == 1 || k == 71));
            check($sformatf("tmo busy k=%0d", k), 32'(busy),
                  32'((k >= 1 && k <= 67) || (k >= 71 && k <= 78)));
            trigger  = (k == 0) || (k == 70);
            drs_busy = (k >= 73 && k <= 74);
        end
        check("tmo evt", event_counter, 32'd8);
        check("tmo lost", 32'(lost_counter), 32'h0000FFFF);

        // Resync in the FIRE cycle: counters and flag clear, resync wins
        holdoff = 12'd0;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clock);
            check($sformatf("rsy drs k=%0d", k), 32'(drs_trigger), 32'(k == 1));
            check($sformatf("rsy busy k=%0d", k), 32'(busy), 32'(k >= 1 && k <= 4));
            if (k == 1) check("rsy evt before", event_counter, 32'd8);
            if (k >= 2) begin
                check($sformatf("rsy evt k=%0d", k), event_counter, 32'd0);
                check($sformatf("rsy lost k=%0d", k), 32'(lost_counter), 32'd0);
                check($sformatf("rsy tmo k=%0d", k), 32'(timeout), 32'd0);
            end
            trigger  = (k == 0);
            resync   = (k == 1);
            drs_busy = (k >= 2 && k <= 3);
        end

        // Reset during DELAY: no start pulse, busy drops the next cycle
        for (int k = 0; k <= 12; k++) begin
            @(negedge clock);
            check($sformatf("rst drs k=%0d", k), 32'(drs_trigger), 32'd0);
            check($sformatf("rst busy k=%0d", k), 32'(busy), 32'(k >= 1 && k <= 3));
            trigger  = (k == 0);
            delay    = (k == 0) ? 8'd5 : 8'd0;
            reset    = (k == 3);
            drs_busy = 1'b0;
        end
        check("rst evt", event_counter, 32'd0);

`ifdef TRIG_PRESCALE_EN
        // Prescale 3: eight spaced edges, pulses on the 4th and 8th only
        begin
            int pulses;
            pulses   = 0;
            prescale = 8'd3;
            for (int k = 0; k <= 79; k++) begin
                @(negedge clock);
                check($sformatf("psc drs k=%0d", k), 32'(drs_trigger), 32'(k == 31 || k == 71));
                if (drs_trigger) pulses++;
                trigger  = (k % 10 == 0);
                drs_busy = (k % 10 == 2) || (k % 10 == 3);
            end
            check("psc pulses", 32'(pulses), 32'd2);
            check("psc evt", event_counter, 32'd2);
            check("psc lost", 32'(lost_counter), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drs_trigger_ctrl.md
Name: drs_trigger_ctrl

Overview:
Trigger sequencer between the registered LVDS trigger input and the DRS control block.
- Detects trigger edges and applies a programmable coarse delay.
- Issues a one-cycle start pulse to the DRS controller, then enforces deadtime until the DRS readout finishes plus a programmable holdoff.
- Owns the accepted-event and lost-event counters, so the top level no longer computes them free-running.

Parameters:
DELAY_W, 8, width of coarse trigger delay (cycles of clock)
HOLDOFF_W, 12, width of post-readout holdoff count
BUSY_TIMEOUT, 64, max cycles to wait for drs_busy_i to rise after a start pulse

Ports:
clock  in  1  system clock (~33 MHz ADC clock domain)
reset  in  1  synchronous, active-high
trigger_i  in  1  registered external trigger level
enable_i  in  1  trigger acceptance enable
resync_i  in  1  one-cycle pulse; clears counters and flags
delay_i  in  DELAY_W  coarse delay, sampled at edge acceptance
holdoff_i  in  HOLDOFF_W  holdoff length, sampled on entering HOLDOFF
drs_busy_i  in  1  busy from the DRS controller
drs_trigger_o  out  1  one-cycle start pulse to the DRS controller
busy_o  out  1  high whenever state != IDLE
event_counter_o  out  32  accepted triggers; wraps
lost_event_counter_o  out  16  rejected triggers; saturates at 0xFFFF
timeout_o  out  1  sticky; DRS never asserted busy after a start pulse

Behaviour:
- Reset: state IDLE. All outputs 0. Internal trigger-delay register 0.
- Edge detect: edge = trigger_i & ~trig_q. trig_q is trigger_i delayed one cycle.
- IDLE:
  - edge & enable_i: accept. Latch delay_i.
  - If delay_i == 0, go to FIRE. Otherwise go to DELAY with cnt = delay_i.
- DELAY: cnt decrements each cycle. When cnt == 1, go to FIRE.
- FIRE:
  - drs_trigger_o = 1 for exactly this cycle.
  - event_counter_o increments.
  - Go to WAIT_BUSY and load the timeout counter.
- Latency: edge seen in cycle N gives drs_trigger_o high in cycle N+1+delay_i.
- WAIT_BUSY:
  - Waits for drs_busy_i = 1, then for drs_busy_i = 0. On the fall, go to HOLDOFF.
  - If drs_busy_i has not risen within BUSY_TIMEOUT cycles of FIRE: set timeout_o and go to HOLDOFF.
  - A drs_busy_i that is already high in the FIRE cycle counts as risen.
- HOLDOFF:
  - Loads holdoff_i on entry.
  - If holdoff_i == 0, return to IDLE on the next cycle. Otherwise count down to IDLE.
- busy_o is registered. It is high from the cycle after acceptance through the last HOLDOFF cycle.
- Lost events:
  - lost_event_counter_o increments on edge & enable_i whenever state != IDLE.
  - It saturates at 0xFFFF.
  - Edges while enable_i = 0 are ignored: not counted, not accepted.
- enable_i falling mid-sequence does not abort the sequence. It completes normally.
- resync_i:
  - Clears event_counter_o, lost_event_counter_o and timeout_o.
  - Does not change state.
  - If resync_i coincides with an increment, resync wins and the counter reads 0.
- Reset mid-sequence: immediate return to IDLE. No drs_trigger_o is issued.
- A trigger held high produces only one edge. It must go low for at least 1 cycle to re-arm.

Optional Feature:
Macro TRIG_PRESCALE_EN.
- With the macro:
  - Adds input prescale_i [7:0] and an internal 8-bit prescale counter.
  - Only every (prescale_i+1)-th IDLE-accepted edge proceeds to DELAY/FIRE.
  - Skipped edges leave the state in IDLE. They count in neither event counter.
  - The prescale counter is cleared by reset and resync_i.
  - prescale_i = 0 means every edge is accepted.
- Without the macro: no prescale port or logic. Every edge accepted in IDLE fires.

Test Plan:
- Basic fire: delay_i=0, holdoff_i=0, single trigger edge at cycle 10 → drs_trigger_o high at cycle 11 only. DRS model busy high cycles 13–20 → busy_o low at cycle 22. event_counter_o = 1.
- Delay and holdoff: delay_i=5, holdoff_i=10 → start pulse at edge+6. busy_o stays high 10 cycles after drs_busy_i falls.
- Deadtime loss: 3 edges during WAIT_BUSY → lost_event_counter_o = 3, event_counter_o = 1. Force lost count to 0xFFFF, add 1 more edge → stays 0xFFFF.
- Timeout: DRS model never asserts busy, BUSY_TIMEOUT = 64 → timeout_o set 64 cycles after FIRE. Returns to IDLE after holdoff. Next edge fires normally.
- Resync/reset collisions: resync_i in the FIRE cycle → event_counter_o = 0. Reset during DELAY → no drs_trigger_o, busy_o = 0 next cycle.
- With TRIG_PRESCALE_EN, prescale_i = 3: 8 edges spaced beyond deadtime → exactly 2 start pulses, on the 4th and 8th edges.
